divider_sequencer: RTL and testbench

//  Iterative restoring divider with controller: accepts dividend/divisor via valid/ready,

---
 rtl/divider_pkg.sv | 19 +
 rtl/div_step.sv | 22 ++
 rtl/divider_sequencer.sv | 122 ++++++++++++
 tb/tb_divider_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared state encoding and width helpers for the iterative restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Working width: a divisor shifted left by (dividend_bits-1) must fit.
  function automatic int add_width(input int divisor_bits, input int dividend_bits);
    return divisor_bits + dividend_bits - 1;
  endfunction

  function automatic int count_width(input int steps);
    return $clog2(steps) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: compare, conditionally subtract, shift divisor and quotient.
module div_step #(
  parameter int ADD_BITS = 29,
  parameter int Q_BITS   = 20
) (
  input  logic [ADD_BITS-1:0] rem_i,
  input  logic [ADD_BITS-1:0] div_i,
  input  logic [Q_BITS-1:0]   q_i,
  output logic [ADD_BITS-1:0] rem_o,
  output logic [ADD_BITS-1:0] div_o,
  output logic [Q_BITS-1:0]   q_o
);

  logic fits;

  // Compare before subtracting so the remainder never goes negative.
  assign fits  = (rem_i >= div_i);
  assign rem_o = fits ? (rem_i - div_i) : rem_i;
  assign div_o = div_i >> 1;
  assign q_o   = {q_i[Q_BITS-2:0], fits};

endmodule

// File: rtl/divider_sequencer.sv
// Restoring divider controller: accepts operands, runs one step per clock, holds result until taken.
module divider_sequencer
  import divider_pkg::*;
#(
  parameter int DIVISOR_BITS  = 10,
  parameter int DIVIDEND_BITS = 20
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIVIDEND_BITS-1:0] in_dividend,
  input  logic [DIVISOR_BITS-1:0]  in_divisor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIVIDEND_BITS-1:0] out_quotient,
  output logic [DIVISOR_BITS-1:0]  out_remainder,
  output logic                     out_div_by_zero,
  output logic                     busy
);

  localparam int ADD_BITS = add_width(DIVISOR_BITS, DIVIDEND_BITS);
  localparam int CNT_BITS = count_width(DIVIDEND_BITS);
  localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(DIVIDEND_BITS - 1);

  div_state_t                 state_q, state_d;
  logic [CNT_BITS-1:0]        count_q, count_d;
  logic [ADD_BITS-1:0]        rem_q, rem_d;
  logic [ADD_BITS-1:0]        div_q, div_d;
  logic [DIVIDEND_BITS-1:0]   q_q, q_d;
  logic                       dbz_q, dbz_d;

  logic [ADD_BITS-1:0]        step_rem, step_div;
  logic [DIVIDEND_BITS-1:0]   step_q;
  logic                       rem_hi_unused;

  div_step #(
    .ADD_BITS (ADD_BITS),
    .Q_BITS   (DIVIDEND_BITS)
  ) u_step (
    .rem_i (rem_q),
    .div_i (div_q),
    .q_i   (q_q),
    .rem_o (step_rem),
    .div_o (step_div),
    .q_o   (step_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_q     <= q_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    div_d   = div_q;
    q_d     = q_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rem_d   = {{(ADD_BITS-DIVIDEND_BITS){1'b0}}, in_dividend};
          div_d   = {in_divisor, {(DIVIDEND_BITS-1){1'b0}}};
          q_d     = '0;
          count_d = '0;
          if (in_divisor == '0) begin
            // Division by zero skips the iteration and reports all-ones.
            state_d = ST_DONE;
            q_d     = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
            dbz_d   = 1'b0;
          end
        end
      end
      ST_CALC: begin
        rem_d   = step_rem;
        div_d   = step_div;
        q_d     = step_q;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready        = (state_q == ST_IDLE);
  assign out_valid       = (state_q == ST_DONE);
  assign busy            = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign out_quotient    = q_q;
  // The final remainder is below the divisor, so the upper working bits are always zero.
  assign out_remainder   = rem_q[DIVISOR_BITS-1:0];
  assign rem_hi_unused   = |rem_q[ADD_BITS-1:DIVISOR_BITS];
  assign out_div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// Randomized and directed checks of divider_sequencer against plain-arithmetic division.
module tb_divider_sequencer;

  localparam int DVS = 10;
  localparam int DVD = 20;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [DVD-1:0] in_dividend;
  logic [DVS-1:0] in_divisor;
  logic           out_valid;
  logic           out_ready;
  logic [DVD-1:0] out_quotient;
  logic [DVS-1:0] out_remainder;
  logic           out_div_by_zero;
  logic           busy;

  int checks = 0;
  int errors = 0;

  divider_sequencer #(
    .DIVISOR_BITS  (DVS),
    .DIVIDEND_BITS (DVD)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_dividend     (in_dividend),
    .in_divisor      (in_divisor),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_quotient    (out_quotient),
    .out_remainder   (out_remainder),
    .out_div_by_zero (out_div_by_zero),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One full transaction; expectations come from integer / and % on the operands.
  task automatic do_op(input logic [DVD-1:0] a, input logic [DVS-1:0] b, input int hold);
    logic [DVD-1:0] eq;
    logic [DVS-1:0] er;
    logic           ed;
    int             lat;
    int             exp_lat;
    if (b == '0) begin
      eq = '1; er = '0; ed = 1'b1; exp_lat = 1;
    end else begin
      eq = DVD'(32'(a) / 32'(b));
      er = DVS'(32'(a) % 32'(b));
      ed = 1'b0;
      exp_lat = DVD + 1;
    end
    @(negedge clock);
    chk("in_ready_before", 32'(in_ready), 1);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    lat = 0;
    do begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      in_valid    = 1'b0;
      in_dividend = DVD'($urandom);
      in_divisor  = DVS'($urandom);
      chk("busy_running", 32'(busy), 1);
    end while (!out_valid && lat < 100);
    chk("out_valid_seen", 32'(out_valid), 1);
    chk("latency", lat, exp_lat);
    chk("quotient", 32'(out_quotient), 32'(eq));
    chk("remainder", 32'(out_remainder), 32'(er));
    chk("div_by_zero", 32'(out_div_by_zero), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      in_valid    = 1'b1;
      in_dividend = DVD'($urandom);
      in_divisor  = DVS'($urandom);
      @(posedge clock);
      @(negedge clock);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_busy", 32'(busy), 1);
      chk("hold_quotient", 32'(out_quotient), 32'(eq));
      chk("hold_remainder", 32'(out_remainder), 32'(er));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    chk("drained_valid", 32'(out_valid), 0);
    chk("drained_in_ready", 32'(in_ready), 1);
    chk("drained_busy", 32'(busy), 0);
    chk("kept_quotient", 32'(out_quotient), 32'(eq));
    chk("kept_remainder", 32'(out_remainder), 32'(er));
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b latency=%0d hold=%0d",
             a, b, out_quotient, out_remainder, out_div_by_zero, lat, hold);
  endtask

  initial begin
    logic [DVD-1:0] ra;
    logic [DVS-1:0] rb;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_quotient", 32'(out_quotient), 0);
    chk("rst_remainder", 32'(out_remainder), 0);
    chk("rst_dbz", 32'(out_div_by_zero), 0);

    do_op(20'd100, 10'd7, 0);
    do_op(20'd5, 10'd9, 0);
    do_op(20'd0, 10'd3, 1);
    do_op(20'd1048575, 10'd1, 0);
    do_op(20'd1048575, 10'd1023, 0);
    do_op(20'd77, 10'd0, 2);
    do_op(20'd1000, 10'd3, 5);

    // Reset in the middle of an iteration aborts it and clears the result.
    @(negedge clock);
    in_valid    = 1'b1;
    in_dividend = 20'd123456;
    in_divisor  = 10'd37;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    chk("pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_in_ready", 32'(in_ready), 1);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_quotient", 32'(out_quotient), 0);
    $display("reset during iteration -> out_valid=%0b in_ready=%0b", out_valid, in_ready);
    do_op(20'd50, 10'd6, 0);

    for (int n = 0; n < 30; n++) begin
      ra = DVD'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = DVS'($urandom_range(1, 15));
        2:       rb = DVS'($urandom_range(1000, 1023));
        default: rb = DVS'($urandom);
      endcase
      do_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
